// File: rtl/aes_key_sched_ctrl_if.sv
// rtl/aes_key_sched_ctrl_if.sv - key-load and round-key read bundle for aes_key_sched_ctrl
//
// Purpose: groups the key-load handshake, status flags and the round-key read
// port of the key-schedule controller.
// Signals:
//   key        nk*32  cipher key, first word in the top 32 bits
//   key_valid  1      key offered
//   key_ready  1      controller can accept a key
//   busy       1      expansion in progress
//   done       1      one-cycle pulse after the last word is written
//   keys_valid 1      full schedule stored
//   rk_idx     4      round-key index to read
//   rk         128    registered round key for the previous rk_idx
// Modports: master (key loader / cipher core), slave (controller).
interface aes_key_sched_ctrl_if #(
  parameter int nk = 4
);
  logic [nk*32-1:0] key;
  logic             key_valid;
  logic             key_ready;
  logic             busy;
  logic             done;
  logic             keys_valid;
  logic [3:0]       rk_idx;
  logic [127:0]     rk;

  modport master (
    output key, key_valid, rk_idx,
    input  key_ready, busy, done, keys_valid, rk
  );

  modport slave (
    input  key, key_valid, rk_idx,
    output key_ready, busy, done, keys_valid, rk
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - iterative one-word-per-cycle AES key expansion with round-key read port
//
// Purpose: accepts a cipher key, expands it one 32-bit word per clock using a
// single SubWord unit and an Rcon register, stores the 4*(nr+1) words and
// serves 128-bit round keys through a registered read port.
// Ports:
//   clk  in  clock, all state changes on the rising edge
//   rst  in  synchronous active-high reset
//   bus  slave modport of aes_key_sched_ctrl_if (handshake, status, read port)
// Parameters: nk (4/6/8 key words), nr (10/12/14 rounds), paired.
module aes_key_sched_ctrl #(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_key_sched_ctrl_if.slave  bus
);

  localparam int         nw       = 4 * (nr + 1);
  localparam logic [5:0] last_idx = 6'(nw - 1);
  localparam logic [5:0] nk_w     = 6'(nk);
  localparam logic [3:0] nk_last  = 4'(nk - 1);
  localparam logic [3:0] nr_w     = 4'(nr);

  if (!((nk == 4 && nr == 10) || (nk == 6 && nr == 12) || (nk == 8 && nr == 14))) begin : g_bad_params
    $error("aes_key_sched_ctrl: unsupported nk/nr pair");
  end

  // S-box computed as the GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t                  state, state_next;
  logic [nw-1:0][31:0]     w;
  logic [5:0]              i;
  logic [3:0]              ki;        // i mod nk, kept as a wrapping counter
  logic [7:0]              rcon;
  logic                    ready_c, busy_c, last_write, accept;
  logic                    done_r, keys_valid_r;
  logic [127:0]            rk_r;
  logic [31:0]             prev, back, sub_in, sub_out, temp, new_word;
  logic [5:0]              base;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready_c    = 1'b1;
    busy_c     = 1'b0;
    last_write = 1'b0;
    case (state)
      IDLE, READY: begin
        if (bus.key_valid) state_next = EXPAND;
      end
      EXPAND: begin
        ready_c = 1'b0;
        busy_c  = 1'b1;
        if (i == last_idx) begin
          last_write = 1'b1;
          state_next = READY;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = bus.key_valid && ready_c;

  // Next word: single-cycle path from w[i-1] through SubWord into the write.
  always_comb begin
    prev    = w[i - 6'd1];
    back    = w[i - nk_w];
    sub_in  = (ki == 4'd0) ? {prev[23:0], prev[31:24]} : prev;
    sub_out = sub_word(sub_in);
    if (ki == 4'd0)                temp = sub_out ^ {rcon, 24'h000000};
    else if (nk > 6 && ki == 4'd4) temp = sub_out;
    else                           temp = prev;
    new_word = back ^ temp;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept)      w[nk-1:0] <= {<<32{bus.key}};
      else if (busy_c) w[i]      <= new_word;
    end
  end

  assign base = {bus.rk_idx, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      i            <= 6'd0;
      ki           <= 4'd0;
      rcon         <= 8'h01;
      done_r       <= 1'b0;
      keys_valid_r <= 1'b0;
      rk_r         <= '0;
    end else begin
      done_r <= last_write;
      if (accept) begin
        i            <= nk_w;
        ki           <= 4'd0;
        rcon         <= 8'h01;
        keys_valid_r <= 1'b0;
      end else if (busy_c) begin
        i  <= i + 6'd1;
        ki <= (ki == nk_last) ? 4'd0 : ki + 4'd1;
        if (ki == 4'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        if (last_write) keys_valid_r <= 1'b1;
      end
      if (bus.rk_idx <= nr_w)
        rk_r <= {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
      else
        rk_r <= '0;
    end
  end

  assign bus.key_ready  = ready_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_r;
  assign bus.keys_valid = keys_valid_r;
  assign bus.rk         = rk_r;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - self-checking bench for aes_key_sched_ctrl (AES-128 and AES-256)
module tb_aes_key_sched_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_key_sched_ctrl_if #(.nk(4)) bus128 ();
  aes_key_sched_ctrl_if #(.nk(8)) bus256 ();

  aes_key_sched_ctrl #(.nk(4), .nr(10)) u_aes128 (.clk(clk), .rst(rst), .bus(bus128));
  aes_key_sched_ctrl #(.nk(8), .nr(14)) u_aes256 (.clk(clk), .rst(rst), .bus(bus256));

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_q  [$];
  logic [127:0] mask_q [$];

  localparam logic [127:0] key_a   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] key_b   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] rk_b10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [255:0] key_256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic [127:0] rk_a [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  // Stimulus helpers (no checking): load a key, wait for done with a bound.
  task automatic accept128(input logic [127:0] k);
    @(negedge clk);
    bus128.key       = k;
    bus128.key_valid = 1'b1;
    @(negedge clk);
    bus128.key_valid = 1'b0;
  endtask

  task automatic accept256(input logic [255:0] k);
    @(negedge clk);
    bus256.key       = k;
    bus256.key_valid = 1'b1;
    @(negedge clk);
    bus256.key_valid = 1'b0;
  endtask

  task automatic wait_done(input bit sel256, output int cycles);
    cycles = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      @(negedge clk);
      if ((sel256 ? bus256.done : bus128.done) === 1'b1) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus128.key = '0; bus128.key_valid = 1'b0; bus128.rk_idx = 4'd0;
    bus256.key = '0; bus256.key_valid = 1'b0; bus256.rk_idx = 4'd0;
    repeat (3) @(negedge clk);
    checks++; if (bus128.key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got %b want 1", bus128.key_ready); end
    checks++; if (bus128.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus128.busy); end
    checks++; if (bus128.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus128.done); end
    checks++; if (bus128.keys_valid !== 1'b0) begin errors++; $display("FAIL reset_keys_valid got %b want 0", bus128.keys_valid); end
    checks++; if (bus128.rk !== 128'h0) begin errors++; $display("FAIL reset_rk got %h want 0", bus128.rk); end
    checks++; if (bus256.key_ready !== 1'b1 || bus256.rk !== 128'h0) begin errors++; $display("FAIL reset_256 got ready=%b rk=%h want ready=1 rk=0", bus256.key_ready, bus256.rk); end
    rst = 1'b0;
  endtask

  task automatic test_aes128();
    int cyc;
    logic [127:0] e;
    accept128(key_a);
    checks++; if (bus128.busy !== 1'b1 || bus128.key_ready !== 1'b0) begin errors++; $display("FAIL a128_busy_after_accept got busy=%b ready=%b want 1/0", bus128.busy, bus128.key_ready); end
    wait_done(1'b0, cyc);
    checks++; if (cyc !== 40) begin errors++; $display("FAIL a128_done_latency got %0d want 40", cyc); end
    checks++; if (bus128.keys_valid !== 1'b1 || bus128.busy !== 1'b0) begin errors++; $display("FAIL a128_status got kv=%b busy=%b want 1/0", bus128.keys_valid, bus128.busy); end
    @(negedge clk);
    checks++; if (bus128.done !== 1'b0) begin errors++; $display("FAIL a128_done_pulse got %b want 0", bus128.done); end
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) begin
        e = exp_q.pop_front();
        checks++; if (bus128.rk !== e) begin errors++; $display("FAIL a128_rk idx=%0d got %h want %h", k - 1, bus128.rk, e); end
      end
      if (k <= 10) begin
        bus128.rk_idx = 4'(k);
        exp_q.push_back(rk_a[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_aes256();
    int cyc;
    logic [127:0] e, m;
    logic [3:0]   idxs [4] = '{4'd0, 4'd1, 4'd2, 4'd14};
    logic [127:0] exps [4] = '{key_256[255:128], key_256[127:0], {32'h9ba35411, 96'h0},
                               128'hfe4890d1e6188d0b046df344706c631e};
    logic [127:0] msks [4] = '{{128{1'b1}}, {128{1'b1}}, {{32{1'b1}}, 96'h0}, {128{1'b1}}};
    accept256(key_256);
    wait_done(1'b1, cyc);
    checks++; if (cyc !== 52) begin errors++; $display("FAIL a256_done_latency got %0d want 52", cyc); end
    checks++; if (bus256.keys_valid !== 1'b1) begin errors++; $display("FAIL a256_keys_valid got %b want 1", bus256.keys_valid); end
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        e = exp_q.pop_front();
        m = mask_q.pop_front();
        checks++; if ((bus256.rk & m) !== e) begin errors++; $display("FAIL a256_rk idx=%0d got %h want %h", idxs[k-1], bus256.rk & m, e); end
      end
      if (k < 4) begin
        bus256.rk_idx = idxs[k];
        exp_q.push_back(exps[k]);
        mask_q.push_back(msks[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ready_bad, rk_bad;
    @(negedge clk);
    bus128.rk_idx    = 4'd0;
    bus128.key       = key_a;
    bus128.key_valid = 1'b1;
    @(negedge clk);
    bus128.key = key_b;
    ready_bad = 1'b0;
    rk_bad    = 1'b0;
    cyc       = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus128.done === 1'b1) begin
        cyc = n;
        break;
      end
      if (bus128.key_ready !== 1'b0) ready_bad = 1'b1;
      if (bus128.rk !== key_a) rk_bad = 1'b1;
    end
    checks++; if (cyc !== 40) begin errors++; $display("FAIL b2b_done_latency got %0d want 40", cyc); end
    checks++; if (ready_bad !== 1'b0) begin errors++; $display("FAIL b2b_key_ready_in_expand got high want low"); end
    checks++; if (rk_bad !== 1'b0) begin errors++; $display("FAIL b2b_rk0_stable got changed want %h", key_a); end
    bus128.rk_idx = 4'd10;
    @(negedge clk);
    bus128.key_valid = 1'b0;
    checks++; if (bus128.rk !== rk_a[10]) begin errors++; $display("FAIL b2b_first_key_rk10 got %h want %h", bus128.rk, rk_a[10]); end
    checks++; if (bus128.keys_valid !== 1'b0 || bus128.busy !== 1'b1) begin errors++; $display("FAIL b2b_reaccept got kv=%b busy=%b want 0/1", bus128.keys_valid, bus128.busy); end
    wait_done(1'b0, cyc);
    checks++; if (cyc !== 40) begin errors++; $display("FAIL b2b_second_latency got %0d want 40", cyc); end
    @(negedge clk);
    checks++; if (bus128.rk !== rk_b10) begin errors++; $display("FAIL b2b_second_key_rk10 got %h want %h", bus128.rk, rk_b10); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bus128.rk_idx = 4'd0;
    accept128(key_a);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus128.busy !== 1'b0 || bus128.keys_valid !== 1'b0 || bus128.key_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_status got busy=%b kv=%b ready=%b want 0/0/1", bus128.busy, bus128.keys_valid, bus128.key_ready);
    end
    checks++; if (bus128.rk !== 128'h0) begin errors++; $display("FAIL rstmid_rk got %h want 0", bus128.rk); end
    accept128(key_a);
    wait_done(1'b0, cyc);
    checks++; if (cyc !== 40) begin errors++; $display("FAIL rstmid_rerun_latency got %0d want 40", cyc); end
  endtask

  task automatic test_read_port();
    logic [127:0] e;
    @(negedge clk);
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) begin
        e = exp_q.pop_front();
        checks++; if (bus128.rk !== e) begin errors++; $display("FAIL read_sweep idx=%0d got %h want %h", k - 1, bus128.rk, e); end
      end
      if (k <= 15) begin
        bus128.rk_idx = 4'(k);
        exp_q.push_back((k <= 10) ? rk_a[k] : 128'h0);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_aes256();
    test_back_to_back();
    test_reset_mid();
    test_read_port();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
